// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: latches decoded control groups and operands,
// assembles two-word LDM, applies hazard stall/flush, counts bubbles.
module id_ex_stage_reg #(
    parameter int DATA_W  = 16,
    parameter int INSTR_W = 16,
    parameter int PC_W    = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               hz_flush,
    input  logic               cu_flush,
    input  logic [3:0]         mem_sig_in,
    input  logic [5:0]         ex_sig_in,
    input  logic [2:0]         wb_sig_in,
    input  logic [INSTR_W-1:0] instr_word,
    input  logic [DATA_W-1:0]  rs_data,
    input  logic [DATA_W-1:0]  rt_data,
    input  logic [2:0]         rd_addr,
    input  logic [PC_W-1:0]    pc_in,
    output logic [3:0]         mem_sig_out,
    output logic [5:0]         ex_sig_out,
    output logic [2:0]         wb_sig_out,
    output logic [INSTR_W-1:0] imm_out,
    output logic [DATA_W-1:0]  rs_out,
    output logic [DATA_W-1:0]  rt_out,
    output logic [2:0]         rd_out,
    output logic [PC_W-1:0]    pc_out,
    output logic               valid_out,
    output logic               imm_pending,
    output logic [CNT_W-1:0]   bubble_cnt
);

    typedef enum logic {S_NORMAL, S_IMM_WAIT} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t              r_state, w_state_nxt;
    logic [3:0]          r_mem, w_mem_nxt;
    logic [5:0]          r_ex, w_ex_nxt;
    logic [2:0]          r_wb, w_wb_nxt;
    logic [INSTR_W-1:0]  r_imm, w_imm_nxt;
    logic [DATA_W-1:0]   r_rs, w_rs_nxt;
    logic [DATA_W-1:0]   r_rt, w_rt_nxt;
    logic [2:0]          r_rd, w_rd_nxt;
    logic [PC_W-1:0]     r_pc, w_pc_nxt;
    logic                r_valid, w_valid_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;

    logic [3:0]          r_h_mem, w_h_mem_nxt;
    logic [5:0]          r_h_ex, w_h_ex_nxt;
    logic [2:0]          r_h_wb, w_h_wb_nxt;
    logic [2:0]          r_h_rd, w_h_rd_nxt;
    logic [PC_W-1:0]     r_h_pc, w_h_pc_nxt;

    logic [2:0]          w_wb_san;
    logic                w_bubble;

    // WBsel is don't-care when regWrite is low; force it clean
    assign w_wb_san = wb_sig_in[2] ? wb_sig_in : 3'b000;

    always_comb begin
        w_state_nxt = r_state;
        w_mem_nxt   = r_mem;
        w_ex_nxt    = r_ex;
        w_wb_nxt    = r_wb;
        w_imm_nxt   = r_imm;
        w_rs_nxt    = r_rs;
        w_rt_nxt    = r_rt;
        w_rd_nxt    = r_rd;
        w_pc_nxt    = r_pc;
        w_valid_nxt = r_valid;
        w_cnt_nxt   = r_cnt;
        w_h_mem_nxt = r_h_mem;
        w_h_ex_nxt  = r_h_ex;
        w_h_wb_nxt  = r_h_wb;
        w_h_rd_nxt  = r_h_rd;
        w_h_pc_nxt  = r_h_pc;
        w_bubble    = 1'b0;

        if (hz_flush) begin
            w_bubble    = 1'b1;
            w_state_nxt = S_NORMAL;
            w_h_mem_nxt = '0;
            w_h_ex_nxt  = '0;
            w_h_wb_nxt  = '0;
            w_h_rd_nxt  = '0;
            w_h_pc_nxt  = '0;
        end else if (!stall) begin
            case (r_state)
                S_NORMAL: begin
                    if (cu_flush) begin
                        w_h_mem_nxt = mem_sig_in;
                        w_h_ex_nxt  = ex_sig_in;
                        w_h_wb_nxt  = w_wb_san;
                        w_h_rd_nxt  = rd_addr;
                        w_h_pc_nxt  = pc_in;
                        w_bubble    = 1'b1;
                        w_state_nxt = S_IMM_WAIT;
                    end else begin
                        w_mem_nxt   = mem_sig_in;
                        w_ex_nxt    = ex_sig_in;
                        w_wb_nxt    = w_wb_san;
                        w_imm_nxt   = '0;
                        w_rs_nxt    = rs_data;
                        w_rt_nxt    = rt_data;
                        w_rd_nxt    = rd_addr;
                        w_pc_nxt    = pc_in;
                        w_valid_nxt = 1'b1;
                    end
                end
                S_IMM_WAIT: begin
                    // current IF/ID word is the immediate, not an instruction
                    w_mem_nxt   = r_h_mem;
                    w_ex_nxt    = r_h_ex;
                    w_wb_nxt    = r_h_wb;
                    w_imm_nxt   = instr_word;
                    w_rs_nxt    = '0;
                    w_rt_nxt    = '0;
                    w_rd_nxt    = r_h_rd;
                    w_pc_nxt    = r_h_pc;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_NORMAL;
                end
                default: w_state_nxt = S_NORMAL;
            endcase
        end

        if (w_bubble) begin
            w_mem_nxt   = '0;
            w_ex_nxt    = '0;
            w_wb_nxt    = '0;
            w_imm_nxt   = '0;
            w_rs_nxt    = '0;
            w_rt_nxt    = '0;
            w_rd_nxt    = '0;
            w_pc_nxt    = '0;
            w_valid_nxt = 1'b0;
            if (r_cnt != '1) w_cnt_nxt = r_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_NORMAL;
            r_mem   <= '0;
            r_ex    <= '0;
            r_wb    <= '0;
            r_imm   <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_rd    <= '0;
            r_pc    <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_h_mem <= '0;
            r_h_ex  <= '0;
            r_h_wb  <= '0;
            r_h_rd  <= '0;
            r_h_pc  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mem   <= w_mem_nxt;
            r_ex    <= w_ex_nxt;
            r_wb    <= w_wb_nxt;
            r_imm   <= w_imm_nxt;
            r_rs    <= w_rs_nxt;
            r_rt    <= w_rt_nxt;
            r_rd    <= w_rd_nxt;
            r_pc    <= w_pc_nxt;
            r_valid <= w_valid_nxt;
            r_cnt   <= w_cnt_nxt;
            r_h_mem <= w_h_mem_nxt;
            r_h_ex  <= w_h_ex_nxt;
            r_h_wb  <= w_h_wb_nxt;
            r_h_rd  <= w_h_rd_nxt;
            r_h_pc  <= w_h_pc_nxt;
        end
    end

    assign mem_sig_out = r_mem;
    assign ex_sig_out  = r_ex;
    assign wb_sig_out  = r_wb;
    assign imm_out     = r_imm;
    assign rs_out      = r_rs;
    assign rt_out      = r_rt;
    assign rd_out      = r_rd;
    assign pc_out      = r_pc;
    assign valid_out   = r_valid;
    assign imm_pending = (r_state == S_IMM_WAIT);
    assign bubble_cnt  = r_cnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: transaction-level model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_id_ex_stage_reg;

    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        rst, stall, hz_flush, cu_flush;
    logic [3:0]  mem_sig_in;
    logic [5:0]  ex_sig_in;
    logic [2:0]  wb_sig_in;
    logic [15:0] instr_word, rs_data, rt_data, pc_in;
    logic [2:0]  rd_addr;
    logic [3:0]  mem_sig_out;
    logic [5:0]  ex_sig_out;
    logic [2:0]  wb_sig_out;
    logic [15:0] imm_out, rs_out, rt_out, pc_out;
    logic [2:0]  rd_out;
    logic        valid_out, imm_pending;
    logic [CW-1:0] bubble_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.DATA_W(16), .INSTR_W(16), .PC_W(16), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .hz_flush(hz_flush),
        .cu_flush(cu_flush), .mem_sig_in(mem_sig_in), .ex_sig_in(ex_sig_in),
        .wb_sig_in(wb_sig_in), .instr_word(instr_word), .rs_data(rs_data),
        .rt_data(rt_data), .rd_addr(rd_addr), .pc_in(pc_in),
        .mem_sig_out(mem_sig_out), .ex_sig_out(ex_sig_out),
        .wb_sig_out(wb_sig_out), .imm_out(imm_out), .rs_out(rs_out),
        .rt_out(rt_out), .rd_out(rd_out), .pc_out(pc_out),
        .valid_out(valid_out), .imm_pending(imm_pending),
        .bubble_cnt(bubble_cnt)
    );

    // Model: what sits in EX, plus an optional half-assembled LDM
    typedef struct packed {
        logic [3:0]  mem;
        logic [5:0]  ex;
        logic [2:0]  wb;
        logic [15:0] imm;
        logic [15:0] rs;
        logic [15:0] rt;
        logic [2:0]  rd;
        logic [15:0] pc;
        logic        valid;
    } slot_t;

    slot_t  m_ex;
    slot_t  m_ldm;
    bit     m_wait;
    int     m_bub;
    bit     m_live = 1'b0;

    function automatic logic [2:0] clean_wb(input logic [2:0] w);
        return w[2] ? w : 3'b000;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ex   = '0;
            m_ldm  = '0;
            m_wait = 0;
            m_bub  = 0;
            m_live = 1'b1;
        end else if (hz_flush) begin
            m_ex   = '0;
            m_wait = 0;
            m_bub  = m_bub + 1;
        end else if (stall) begin
            m_ex = m_ex;
        end else if (m_wait) begin
            m_ex       = m_ldm;
            m_ex.imm   = instr_word;
            m_ex.valid = 1'b1;
            m_wait     = 0;
        end else if (cu_flush) begin
            m_ldm = '{mem_sig_in, ex_sig_in, clean_wb(wb_sig_in),
                      16'h0, 16'h0, 16'h0, rd_addr, pc_in, 1'b0};
            m_ex   = '0;
            m_wait = 1;
            m_bub  = m_bub + 1;
        end else begin
            m_ex = '{mem_sig_in, ex_sig_in, clean_wb(wb_sig_in),
                     16'h0, rs_data, rt_data, rd_addr, pc_in, 1'b1};
        end
    end

    logic [85:0] act, expv;
    assign act = {mem_sig_out, ex_sig_out, wb_sig_out, imm_out, rs_out,
                  rt_out, rd_out, pc_out, valid_out, imm_pending, bubble_cnt};

    always @(negedge clk) begin
        if (m_live) begin
            expv = {m_ex, m_wait, (m_bub > 15) ? 4'hF : 4'(m_bub)};
            n_vec++;
            if (act !== expv) begin
                n_err++;
                $display("FAIL model t=%0t got=%h want=%h", $time, act, expv);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", nm, a, e);
        end
    endtask

    task automatic idle();
        rst = 0; stall = 0; hz_flush = 0; cu_flush = 0;
        mem_sig_in = '0; ex_sig_in = '0; wb_sig_in = '0;
        instr_word = '0; rs_data = '0; rt_data = '0;
        rd_addr = '0; pc_in = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ldm(input logic [2:0] rd, input logic [15:0] pc);
        idle();
        cu_flush = 1; mem_sig_in = 4'b1000; wb_sig_in = 3'b110;
        rd_addr = rd; pc_in = pc; rs_data = 16'hAAAA;
        cyc();
    endtask

    initial begin
        idle();
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            {mem_sig_in, ex_sig_in, wb_sig_in} = 13'($urandom);
            {stall, hz_flush, cu_flush} = 3'($urandom);
            rs_data = 16'($urandom); rt_data = 16'($urandom);
            instr_word = 16'($urandom); pc_in = 16'($urandom);
            cyc();
        end
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_cnt", 32'(bubble_cnt), 0);
        chk("rst_pend", 32'(imm_pending), 0);
        chk("rst_rs", 32'(rs_out), 0);

        idle();
        ex_sig_in = 6'b001010; wb_sig_in = 3'b101; rd_addr = 3;
        rs_data = 16'h0005; rt_data = 16'h0007; pc_in = 16'h0010;
        cyc();
        chk("add_ex", 32'(ex_sig_out), 32'b001010);
        chk("add_rs", 32'(rs_out), 5);
        chk("add_rt", 32'(rt_out), 7);
        chk("add_valid", 32'(valid_out), 1);

        ldm(3'd2, 16'h0020);
        chk("ldm1_valid", 32'(valid_out), 0);
        chk("ldm1_pend", 32'(imm_pending), 1);
        chk("ldm1_cnt", 32'(bubble_cnt), 1);
        idle();
        instr_word = 16'hBEEF; cu_flush = 1; mem_sig_in = 4'b0100;
        cyc();
        chk("ldm2_mem", 32'(mem_sig_out), 32'b1000);
        chk("ldm2_wb", 32'(wb_sig_out), 32'b110);
        chk("ldm2_rd", 32'(rd_out), 2);
        chk("ldm2_imm", 32'(imm_out), 32'hBEEF);
        chk("ldm2_rs", 32'(rs_out), 0);
        chk("ldm2_valid", 32'(valid_out), 1);
        chk("ldm2_pend", 32'(imm_pending), 0);

        ldm(3'd5, 16'h0030);
        for (int i = 0; i < 3; i++) begin
            idle();
            stall = 1; instr_word = 16'($urandom);
            cyc();
            chk("stall_pend", 32'(imm_pending), 1);
            chk("stall_valid", 32'(valid_out), 0);
        end
        idle();
        instr_word = 16'h1234;
        cyc();
        chk("stall_imm", 32'(imm_out), 32'h1234);
        chk("stall_rd", 32'(rd_out), 5);
        chk("stall_cnt", 32'(bubble_cnt), 2);

        ldm(3'd6, 16'h0040);
        idle();
        hz_flush = 1; instr_word = 16'h5555;
        cyc();
        chk("hzf_valid", 32'(valid_out), 0);
        chk("hzf_pend", 32'(imm_pending), 0);
        chk("hzf_cnt", 32'(bubble_cnt), 4);
        idle();
        rs_data = 16'h0101; rd_addr = 1; instr_word = 16'h7777;
        cyc();
        chk("hzf_after_imm", 32'(imm_out), 0);
        chk("hzf_after_rd", 32'(rd_out), 1);

        ldm(3'd7, 16'h0050);
        idle();
        cu_flush = 1; instr_word = 16'hC0DE;
        cyc();
        chk("b2b_imm", 32'(imm_out), 32'hC0DE);
        chk("b2b_pend", 32'(imm_pending), 0);

        idle();
        mem_sig_in = 4'b0110; wb_sig_in = 3'b0x1;
        cyc();
        chk("std_wb_x", 32'(wb_sig_out), 0);
        idle();
        wb_sig_in = 3'b011; rt_data = 16'h00FF;
        cyc();
        chk("std_wb", 32'(wb_sig_out), 0);

        idle();
        stall = 1; rs_data = 16'hDEAD;
        cyc();
        chk("stall_norm_rt", 32'(rt_out), 32'h00FF);

        idle();
        stall = 1; hz_flush = 1; rs_data = 16'hDEAD;
        cyc();
        chk("flush_stall_valid", 32'(valid_out), 0);
        chk("flush_stall_cnt", 32'(bubble_cnt), 6);

        idle();
        hz_flush = 1;
        for (int i = 0; i < 12; i++) cyc();
        chk("sat_cnt", 32'(bubble_cnt), 32'hF);

        idle();
        rst = 1;
        cyc();
        chk("rst2_cnt", 32'(bubble_cnt), 0);
        idle();
        cyc();

        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
